// File: rtl/pll_reset_ctrl.sv
// Clock-wizard bring-up sequencer: pulses pll_reset, waits for a stable lock, then
// releases the write-side reset and, GAP cycles later, the read-side reset.
module pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int MAX_RETRY      = 3,
  parameter int REL_DLY        = 200,
  parameter int GAP            = 8
) (
  input  logic       clkin_50M,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       soft_req,
  output logic       pll_reset,
  output logic       reset_1,
  output logic       reset_2,
  output logic       ready,
  output logic       error,
  output logic [1:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam logic [2:0] PLL_RST   = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] REL_1     = 3'd3;
  localparam logic [2:0] REL_2     = 3'd4;
  localparam logic [2:0] RUN       = 3'd5;
  localparam logic [2:0] FAULT     = 3'd6;

  localparam int CMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CMAX_B = (REL_DLY > GAP) ? REL_DLY : GAP;
  localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int CNT_W  = $clog2(CMAX + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lock_p0;
  logic             lock_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0 -> lock_s: two-flop synchroniser for the asynchronous lock status
  always_ff @(posedge clkin_50M or negedge reset_n) begin
    if (!reset_n) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= locked;
      lock_s  <= lock_p0;
    end
  end

  always_ff @(posedge clkin_50M or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_reset <= 1'b1;
      reset_1   <= 1'b1;
      reset_2   <= 1'b1;
      ready     <= 1'b0;
      error     <= 1'b0;
      retry_cnt <= 2'd0;
      lost_cnt  <= 8'd0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= CNT_W'(1);
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            retry_cnt <= retry_cnt + 2'd1;
            cnt       <= '0;
            if (retry_cnt + 2'd1 == 2'(MAX_RETRY)) begin
              state <= FAULT;
              error <= 1'b1;
            end else begin
              state     <= PLL_RST;
              pll_reset <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          // cnt already includes the lock_s cycle that brought us here
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CNT_W'(REL_DLY - 1)) begin
            state <= REL_1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL_1: begin
          reset_1 <= 1'b0;
          if (cnt == CNT_W'(GAP - 1)) begin
            state <= REL_2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL_2: begin
          state     <= RUN;
          reset_2   <= 1'b0;
          ready     <= 1'b1;
          retry_cnt <= 2'd0;
        end
        RUN: begin
          if (!lock_s || soft_req) begin
            if (!lock_s)
              lost_cnt <= sat_inc8(lost_cnt);
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            reset_1   <= 1'b1;
            reset_2   <= 1'b1;
            ready     <= 1'b0;
          end
        end
        FAULT: begin
          if (soft_req) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            error     <= 1'b0;
            retry_cnt <= 2'd0;
          end
        end
        default: begin
          state     <= PLL_RST;
          cnt       <= '0;
          pll_reset <= 1'b1;
          reset_1   <= 1'b1;
          reset_2   <= 1'b1;
          ready     <= 1'b0;
          error     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench: stimulus queues each expected output-vector change with its cycle;
// a negedge monitor pops one entry per observed change and compares.
module tb_pll_reset_ctrl;

  logic       clkin_50M = 1'b0;
  logic       reset_n;
  logic       locked;
  logic       soft_req;
  logic       pll_reset, reset_1, reset_2, ready, error;
  logic [1:0] retry_cnt;
  logic [7:0] lost_cnt;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32), .MAX_RETRY(2), .REL_DLY(10), .GAP(3)
  ) dut (
    .clkin_50M(clkin_50M), .reset_n(reset_n), .locked(locked), .soft_req(soft_req),
    .pll_reset(pll_reset), .reset_1(reset_1), .reset_2(reset_2), .ready(ready),
    .error(error), .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
  );

  always #5 clkin_50M = ~clkin_50M;

  typedef struct {
    int          cyc;
    logic [14:0] vec;
  } ev_t;

  ev_t         expq[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [14:0] last_vec = 'x;

  always @(posedge clkin_50M) cyc <= cyc + 1;

  function automatic logic [14:0] mk(input logic pr, input logic r1, input logic r2,
                                     input logic rdy, input logic err,
                                     input logic [1:0] rt, input logic [7:0] lc);
    return {pr, r1, r2, rdy, err, rt, lc};
  endfunction

  function automatic logic [14:0] outs();
    return {pll_reset, reset_1, reset_2, ready, error, retry_cnt, lost_cnt};
  endfunction

  localparam logic [14:0] RSTV = 15'b111_0_0_00_00000000;

  task automatic push(input int c, input logic [14:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    expq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin_50M);
    #1;
  endtask

  // Monitor: every change in the registered outputs must match the next expected event
  always @(negedge clkin_50M) begin
    logic [14:0] v;
    ev_t         e;
    v = outs();
    if (v !== last_vec) begin
      last_vec = v;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d actual=%b required=no change", cyc, v);
      end else begin
        e = expq.pop_front();
        if (v !== e.vec || (e.cyc >= 0 && e.cyc != cyc)) begin
          failures++;
          $display("FAIL event cyc=%0d actual=%b required cyc=%0d vec=%b",
                   cyc, v, e.cyc, e.vec);
        end
      end
    end
  end

  initial begin
    int b, l, f, g, h, s, b2;
    reset_n  = 1'b0;
    locked   = 1'b0;
    soft_req = 1'b0;
    push(-1, RSTV);

    // Normal bring-up
    tick(3);
    reset_n = 1'b1;
    b = cyc;
    push(b + 4, mk(0, 1, 1, 0, 0, 2'd0, 8'd0));
    tick(20);
    locked = 1'b1;
    l = cyc;
    push(l + 13, mk(0, 0, 1, 0, 0, 2'd0, 8'd0));
    push(l + 16, mk(0, 0, 0, 1, 0, 2'd0, 8'd0));
    tick(25);

    // Lock loss in RUN with soft_req in the same cycle, then lock never returns
    locked = 1'b0;
    f = cyc;
    push(f + 3,  mk(1, 1, 1, 0, 0, 2'd0, 8'd1));
    push(f + 7,  mk(0, 1, 1, 0, 0, 2'd0, 8'd1));
    push(f + 39, mk(1, 1, 1, 0, 0, 2'd1, 8'd1));
    push(f + 43, mk(0, 1, 1, 0, 0, 2'd1, 8'd1));
    push(f + 75, mk(0, 1, 1, 0, 1, 2'd2, 8'd1));
    tick(2);
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(77);

    // Recover from FAULT with soft_req
    g = cyc;
    soft_req = 1'b1;
    push(g + 1, mk(1, 1, 1, 0, 0, 2'd0, 8'd1));
    push(g + 5, mk(0, 1, 1, 0, 0, 2'd0, 8'd1));
    tick(1);
    soft_req = 1'b0;
    tick(9);

    // Lock glitch: high 5, low 2, high; soft_req during STABLE is ignored
    h = cyc;
    locked = 1'b1;
    push(h + 20, mk(0, 0, 1, 0, 0, 2'd0, 8'd1));
    push(h + 23, mk(0, 0, 0, 1, 0, 2'd0, 8'd1));
    tick(5);
    locked = 1'b0;
    tick(2);
    locked = 1'b1;
    tick(5);
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(15);

    // soft_req alone in RUN: lost_cnt unchanged
    s = cyc;
    soft_req = 1'b1;
    push(s + 1,  mk(1, 1, 1, 0, 0, 2'd0, 8'd1));
    push(s + 5,  mk(0, 1, 1, 0, 0, 2'd0, 8'd1));
    push(s + 16, mk(0, 0, 1, 0, 0, 2'd0, 8'd1));
    tick(1);
    soft_req = 1'b0;
    tick(16);

    // Asynchronous reset mid-cycle while in REL_1
    #1;
    push(s + 17, RSTV);
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== RSTV) begin
      failures++;
      $display("FAIL async_reset actual=%b required=%b", outs(), RSTV);
    end
    tick(3);
    reset_n = 1'b1;
    b2 = cyc;
    push(b2 + 4,  mk(0, 1, 1, 0, 0, 2'd0, 8'd0));
    push(b2 + 15, mk(0, 0, 1, 0, 0, 2'd0, 8'd0));
    push(b2 + 18, mk(0, 0, 0, 1, 0, 2'd0, 8'd0));
    tick(25);

    while (expq.size() != 0) begin
      ev_t e;
      e = expq.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event actual=none required cyc=%0d vec=%b", e.cyc, e.vec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
